// File: rtl/ob_serializer_param_if.sv
// ob_serializer_param_if: packet-in / byte-out bundle for ob_serializer_param.
// ovf_count exists only when OB_OVF_COUNT_EN is defined.
interface ob_serializer_param_if #(
  parameter int PKT_BYTES = 4,
  parameter int BYTE_W    = 8,
  parameter int DEPTH     = 8
);
  localparam int PW = PKT_BYTES * BYTE_W;
  localparam int CW = $clog2(DEPTH + 1);

  logic              pkt_avail;
  logic [PW-1:0]     pkt;
  logic              full;
  logic [CW-1:0]     count;
  logic              read_from_ob;
  logic              ob_ready;
  logic [BYTE_W-1:0] payload_outbound;
  logic              put_outbound;
  logic              busy;
`ifdef OB_OVF_COUNT_EN
  logic [15:0]       ovf_count;
`endif

  modport master (
`ifdef OB_OVF_COUNT_EN
    input  ovf_count,
`endif
    output pkt_avail, pkt, read_from_ob, ob_ready,
    input  full, count, payload_outbound,
    input  put_outbound, busy
  );

  modport slave (
`ifdef OB_OVF_COUNT_EN
    output ovf_count,
`endif
    input  pkt_avail, pkt, read_from_ob, ob_ready,
    output full, count, payload_outbound,
    output put_outbound, busy
  );
endinterface

// File: rtl/ob_serializer_param.sv
// ob_serializer_param: packet FIFO feeding an MSB-byte-first serialiser.
// Define OB_OVF_COUNT_EN to add the saturating dropped-write counter.
module ob_serializer_param #(
  parameter int PKT_BYTES = 4,
  parameter int BYTE_W    = 8,
  parameter int DEPTH     = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ob_serializer_param_if.slave  bus
);
  localparam int PW = PKT_BYTES * BYTE_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(PKT_BYTES);
  localparam logic [IW-1:0] LAST = IW'(PKT_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full;
  logic [PKT_BYTES-1:0][BYTE_W-1:0] stage;
  logic [IW-1:0] idx, idx_nxt, sel;
  logic          push, pop;

  // a full FIFO refuses writes even when a pop frees a slot
  assign push = bus.pkt_avail && !full;
  assign sel  = LAST - idx;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // next-state, byte index and pop decision
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (bus.read_from_ob) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (bus.ob_ready) begin
          if (idx == LAST) begin
            idx_nxt = '0;
            if (count != '0) begin
              pop       = 1'b1;
              state_nxt = LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, pointers, occupancy and staging register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      stage  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        stage  <= mem[rd_ptr];
      end
    end
  end

  // packet storage, no reset needed: pointers define validity
  always_ff @(posedge clock) begin
    if (reset_n && push) mem[wr_ptr] <= bus.pkt;
  end

`ifdef OB_OVF_COUNT_EN
  logic [15:0] ovf_count;

  // dropped-write counter, saturating
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (bus.pkt_avail && full && ovf_count != 16'hFFFF) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

  assign bus.ovf_count = ovf_count;
`endif

  assign bus.full  = full;
  assign bus.count = count;
  assign bus.busy  = (state != IDLE);
  assign bus.put_outbound = (state == SEND);
  assign bus.payload_outbound =
    (state == SEND) ? stage[sel] : '0;
endmodule
